rom_loader_ctrl: RTL

- Generalised ROM download controller for arcade cores: captures data_io byte writes, buffers them in a small FIFO and issues each byte to NPORTS SDRAM ports.
- SDRAM ports use toggle req/ack handshakes; every byte is written to every port enabled in PORT_MASK.
- Also generates the core reset and the rom_loaded flag.
- Sits between data_io, sdram and the core top (target_top).

---
 rtl/rom_loader_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/rom_loader_ctrl.sv
// ROM download controller: captures data_io byte writes into a small FIFO and issues each
// byte to every enabled SDRAM port over toggle req/ack handshakes; also owns the core reset.
module rom_loader_ctrl #(
  parameter int unsigned       NPORTS     = 2,
  parameter logic [NPORTS-1:0] PORT_MASK  = 2'b11,
  parameter int unsigned       DEPTH_LOG2 = 2,
  parameter logic [7:0]        ROM_INDEX  = 8'd0,
  parameter logic [15:0]       RESET_HOLD = 16'hffff
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_downl,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              reset_req,
  output logic [NPORTS-1:0] port_req,
  input  logic [NPORTS-1:0] port_ack,
  output logic [22:0]       port_a,
  output logic [1:0]        port_ds,
  output logic [15:0]       port_d,
  output logic              port_we,
  output logic              busy,
  output logic              overflow,
  output logic              rom_loaded,
  output logic              core_reset
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = (DEPTH_LOG2 + 1)'(1);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  // Input edge detection and acceptance
  logic accept;
  logic wr_q;
  logic accept_q;
  logic push_req;
  logic addr_unused;

  assign accept      = ioctl_downl && (ioctl_index == ROM_INDEX);
  assign push_req    = ioctl_wr && !wr_q && accept;
  assign addr_unused = ioctl_addr[24];

  // FIFO of {addr[23:0], data[7:0]}
  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  full;
  logic                  push;
  logic                  drop;
  logic                  pop;
  logic [31:0]           head;

  // Occupancy never exceeds DEPTH, so its MSB alone marks "full".
  assign full = count_q[DEPTH_LOG2];
  assign push = push_req && !full;
  assign drop = push_req && full;
  assign head = mem[rptr_q];

  // Handshake FSM and registered port outputs
  state_t            state_q;
  logic [NPORTS-1:0] req_q;
  logic [22:0]       port_a_q;
  logic [1:0]        port_ds_q;
  logic [15:0]       port_d_q;
  logic              acks_done;

  assign pop       = (state_q == S_IDLE) && (count_q != '0);
  assign acks_done = ((port_ack ^ req_q) & PORT_MASK) == '0;

  // Status and core reset
  logic        overflow_q;
  logic        rom_loaded_q;
  logic        core_reset_q;
  logic [15:0] rst_cnt_q, rst_cnt_d;
  logic        hold_reload;

  assign busy        = (count_q != '0) || (state_q == S_WAIT);
  assign hold_reload = reset_req || !rom_loaded_q || ioctl_downl || busy;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + PTR_ONE;
    if (pop)  rptr_d = rptr_q + PTR_ONE;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    if (hold_reload)            rst_cnt_d = RESET_HOLD;
    else if (rst_cnt_q != '0)   rst_cnt_d = rst_cnt_q - 16'd1;
    else                        rst_cnt_d = '0;
  end

  always_ff @(posedge clk_sys) begin
    if (push) mem[wptr_q] <= {ioctl_addr[23:0], ioctl_dout};
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      req_q     <= '0;
      port_a_q  <= '0;
      port_ds_q <= '0;
      port_d_q  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (pop) begin
            port_a_q  <= head[31:9];
            port_ds_q <= {head[8], ~head[8]};
            port_d_q  <= {2{head[7:0]}};
            req_q     <= req_q ^ PORT_MASK;
            state_q   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (acks_done) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_q         <= 1'b0;
      accept_q     <= 1'b0;
      overflow_q   <= 1'b0;
      rom_loaded_q <= 1'b0;
      rst_cnt_q    <= RESET_HOLD;
      core_reset_q <= 1'b1;
    end else begin
      wr_q     <= ioctl_wr;
      accept_q <= accept;
      if (drop)                    overflow_q <= 1'b1;
      else if (accept && !accept_q) overflow_q <= 1'b0;
      if (accept && !accept_q)      rom_loaded_q <= 1'b0;
      else if (!accept && accept_q) rom_loaded_q <= 1'b1;
      rst_cnt_q    <= rst_cnt_d;
      core_reset_q <= (rst_cnt_d != '0);
    end
  end

  assign port_req   = req_q;
  assign port_a     = port_a_q;
  assign port_ds    = port_ds_q;
  assign port_d     = port_d_q;
  assign port_we    = accept_q;
  assign overflow   = overflow_q;
  assign rom_loaded = rom_loaded_q;
  assign core_reset = core_reset_q;

endmodule
